// File: rtl/clk_sel_ctrl.sv
// Debounced, lock-qualified select generator for a BUFGMUX tree.
// Also provides a free-running heartbeat and a saturating switch-event counter.
module clk_sel_ctrl #(
    parameter int SEL_W           = 1,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SETTLE_CYCLES   = 16,
    parameter int CNT_W           = 27,
    parameter int HEARTBEAT_BIT   = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEL_W-1:0] sel_req,
    input  logic             locked,
    output logic [SEL_W-1:0] sel,
    output logic             sel_valid,
    output logic             busy,
    output logic             heartbeat,
    output logic [7:0]       switch_count
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [DW-1:0] DLOAD = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SW-1:0] SLOAD = SW'(SETTLE_CYCLES - 1);

    localparam logic [1:0] WAIT_LOCK = 2'd0;
    localparam logic [1:0] IDLE      = 2'd1;
    localparam logic [1:0] DEBOUNCE  = 2'd2;
    localparam logic [1:0] SETTLE    = 2'd3;

    logic [SEL_W-1:0] req_meta_q, req_s_q;
    logic             lock_meta_q, lock_s_q;
    logic [CNT_W-1:0] cnt_q;

    logic [1:0]       state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] cand_q, cand_d;
    logic [DW-1:0]    dcnt_q, dcnt_d;
    logic [SW-1:0]    scnt_q, scnt_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic [7:0]       swcnt_q, swcnt_d;

    // Two-flop synchronisers; nothing else looks at the raw switch/lock pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_meta_q  <= '0;
            req_s_q     <= '0;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            req_meta_q  <= sel_req;
            req_s_q     <= req_meta_q;
            lock_meta_q <= locked;
            lock_s_q    <= lock_meta_q;
            cnt_q       <= cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cand_d  = cand_q;
        dcnt_d  = dcnt_q;
        scnt_d  = scnt_q;
        valid_d = valid_q;
        swcnt_d = swcnt_q;
        // Lock loss dominates everything, including a same-cycle apply.
        if (!lock_s_q) begin
            state_d = WAIT_LOCK;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    state_d = IDLE;
                    valid_d = 1'b1;
                end
                IDLE: begin
                    valid_d = 1'b1;
                    if (req_s_q != sel_q) begin
                        cand_d  = req_s_q;
                        dcnt_d  = DLOAD;
                        state_d = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (req_s_q == sel_q) begin
                        state_d = IDLE;
                    end else if (req_s_q != cand_q) begin
                        cand_d = req_s_q;
                        dcnt_d = DLOAD;
                    end else if (dcnt_q == '0) begin
                        sel_d   = cand_q;
                        valid_d = 1'b0;
                        if (swcnt_q != 8'hFF) swcnt_d = swcnt_q + 8'd1;
                        scnt_d  = SLOAD;
                        state_d = SETTLE;
                    end else begin
                        dcnt_d = dcnt_q - DW'(1);
                    end
                end
                SETTLE: begin
                    valid_d = 1'b0;
                    if (scnt_q == '0) begin
                        state_d = IDLE;
                        valid_d = 1'b1;
                    end else begin
                        scnt_d = scnt_q - SW'(1);
                    end
                end
                default: begin
                    state_d = WAIT_LOCK;
                    valid_d = 1'b0;
                end
            endcase
        end
        busy_d = (state_d == DEBOUNCE) || (state_d == SETTLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WAIT_LOCK;
            sel_q   <= '0;
            cand_q  <= '0;
            dcnt_q  <= '0;
            scnt_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            swcnt_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cand_q  <= cand_d;
            dcnt_q  <= dcnt_d;
            scnt_q  <= scnt_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            swcnt_q <= swcnt_d;
        end
    end

    assign sel          = sel_q;
    assign sel_valid    = valid_q;
    assign busy         = busy_q;
    assign heartbeat    = cnt_q[HEARTBEAT_BIT];
    assign switch_count = swcnt_q;

endmodule
